// File: rtl/mix_columns_iter.sv
// ---------------------------------------------------------------------------
// mix_columns_iter : iterative AES MixColumns, one column per clock, final-round bypass.
// Optional InvMixColumns enabled by MIX_COLUMNS_INV_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mix_columns_iter (
  input  logic         CLK,
  input  logic         RST,
  input  logic [0:127] bytes,
  input  logic         enable,
  input  logic         last_round,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inverse,
`endif
  output logic [0:127] mix_cols,
  output logic         done_flag,
  output logic         busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [0:127] state_q, state_d;
  logic [0:127] mix_cols_q, mix_cols_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic         lr_q, lr_d;
  logic         done_flag_q, done_flag_d;
  logic         busy_q, busy_d;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
            mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  logic inv_q, inv_d;

  // Inverse coefficients all derive from the x2/x4/x8 chain of one byte.
  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction
  function automatic logic [7:0] mulb(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction
  function automatic logic [7:0] muld(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction
  function automatic logic [7:0] mule(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

  assign col_out = inv_q ? inv_mix(col_in) : fwd_mix(col_in);
`else
  assign col_out = fwd_mix(col_in);
`endif

  // Single shared column mixer, addressed by the column counter.
  assign col_in = state_q[{col_cnt_q, 5'b0} +: 32];

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    mix_cols_d  = mix_cols_q;
    col_cnt_d   = col_cnt_q;
    lr_d        = lr_q;
    done_flag_d = 1'b0;
    busy_d      = busy_q;
`ifdef MIX_COLUMNS_INV_EN
    inv_d       = inv_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (enable) begin
          state_d   = bytes;
          lr_d      = last_round;
`ifdef MIX_COLUMNS_INV_EN
          inv_d     = inverse;
`endif
          col_cnt_d = 2'd0;
          busy_d    = 1'b1;
          fsm_d     = RUN;
        end
      end
      RUN: begin
        if (lr_q) begin
          mix_cols_d  = state_q;
          done_flag_d = 1'b1;
          busy_d      = 1'b0;
          fsm_d       = IDLE;
        end else begin
          state_d[{col_cnt_q, 5'b0} +: 32] = col_out;
          col_cnt_d = col_cnt_q + 2'd1;
          if (col_cnt_q == 2'd3) begin
            mix_cols_d  = state_d;
            done_flag_d = 1'b1;
            busy_d      = 1'b0;
            fsm_d       = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      mix_cols_q  <= '0;
      col_cnt_q   <= 2'd0;
      lr_q        <= 1'b0;
      done_flag_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      mix_cols_q  <= mix_cols_d;
      col_cnt_q   <= col_cnt_d;
      lr_q        <= lr_d;
      done_flag_q <= done_flag_d;
      busy_q      <= busy_d;
`ifdef MIX_COLUMNS_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign mix_cols  = mix_cols_q;
  assign done_flag = done_flag_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_iter : directed + random check of mix_columns_iter against a GF(2^8) matrix model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mix_columns_iter;

  logic         CLK;
  logic         RST;
  logic [0:127] bytes;
  logic         enable;
  logic         last_round;
`ifdef MIX_COLUMNS_INV_EN
  logic         inverse;
`endif
  logic [0:127] mix_cols;
  logic         done_flag;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [0:127] last_out;

  mix_columns_iter dut (
    .CLK        (CLK),
    .RST        (RST),
    .bytes      (bytes),
    .enable     (enable),
    .last_round (last_round),
`ifdef MIX_COLUMNS_INV_EN
    .inverse    (inverse),
`endif
    .mix_cols   (mix_cols),
    .done_flag  (done_flag),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Generic GF(2^8) multiply, AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // Reference: circulant matrix multiply per column, or identity on the last round.
  function automatic logic [0:127] mix_model(input logic [0:127] s, input bit lr, input bit inv);
    logic [7:0]   coef [4];
    logic [0:127] r;
    logic [7:0]   acc;
    r = s;
    if (lr) return r;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - row + 4) % 4], s[32*c + 8*j +: 8]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_inv(input bit inv);
`ifdef MIX_COLUMNS_INV_EN
    inverse = inv;
`else
    if (inv) $display("note: inverse requested without MIX_COLUMNS_INV_EN");
`endif
  endtask

  // One operation from an idle DUT, checking every cycle up to one past done.
  task automatic run_op(input string tag, input logic [0:127] din, input bit lr,
                        input bit inv, input logic [0:127] exp);
    int lat;
    lat = lr ? 1 : 4;
    @(negedge CLK);
    bytes = din; last_round = lr; drive_inv(inv); enable = 1'b1;
    @(negedge CLK);
    enable = 1'b0; bytes = rnd128(); last_round = ~lr; drive_inv(~inv & inv);
    chk({tag, ".busy_e0"}, {127'd0, busy}, 128'd1);
    chk({tag, ".done_e0"}, {127'd0, done_flag}, 128'd0);
    for (int n = 1; n <= lat; n++) begin
      @(negedge CLK);
      if (n < lat) begin
        chk({tag, ".done_mid"}, {127'd0, done_flag}, 128'd0);
        chk({tag, ".hold_mid"}, mix_cols, last_out);
      end else begin
        chk({tag, ".done"}, {127'd0, done_flag}, 128'd1);
        chk({tag, ".result"}, mix_cols, exp);
        chk({tag, ".busy_done"}, {127'd0, busy}, 128'd0);
      end
    end
    last_out = exp;
    @(negedge CLK);
    chk({tag, ".done_drop"}, {127'd0, done_flag}, 128'd0);
    chk({tag, ".hold_after"}, mix_cols, exp);
  endtask

  initial begin
    logic [0:127] a, b, r1_in, r1_out;
    bit lr, inv;

    r1_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    r1_out = 128'h046681e5e0cb199a48f8d37a2806264c;

    // Reset and idle quiet period
    RST = 1'b0; enable = 1'b0; last_round = 1'b0; bytes = '0; drive_inv(1'b0);
    last_out = '0;
    @(negedge CLK);
    chk("rst.mix_cols", mix_cols, 128'd0);
    chk("rst.done", {127'd0, done_flag}, 128'd0);
    chk("rst.busy", {127'd0, busy}, 128'd0);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bytes = rnd128();
      @(negedge CLK);
      chk("idle.mix_cols", mix_cols, 128'd0);
      chk("idle.done", {127'd0, done_flag}, 128'd0);
      chk("idle.busy", {127'd0, busy}, 128'd0);
    end

    // Directed vectors
    run_op("fips_r1", r1_in, 1'b0, 1'b0, r1_out);
    run_op("col_a", 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0,
           128'h8e4da1bc9fdc589d01010101c6c6c6c6);
    run_op("col_b", 128'hd4d4d4d52d26314c0000000000000000, 1'b0, 1'b0,
           128'hd5d5d7d64d7ebdf80000000000000000);
    run_op("last", r1_in, 1'b1, 1'b0, r1_in);
`ifdef MIX_COLUMNS_INV_EN
    run_op("inv_r1", r1_out, 1'b0, 1'b1, r1_in);
    run_op("inv_last", r1_out, 1'b1, 1'b1, r1_out);
`endif

    // Random operations against the matrix model
    for (int i = 0; i < 24; i++) begin
      a   = rnd128();
      lr  = ($urandom_range(0, 3) == 0);
`ifdef MIX_COLUMNS_INV_EN
      inv = $urandom_range(0, 1) == 1;
`else
      inv = 1'b0;
`endif
      run_op("rand", a, lr, inv, mix_model(a, lr, inv));
    end

    // Enable while busy is ignored
    a = rnd128(); b = rnd128();
    @(negedge CLK);
    bytes = a; last_round = 1'b0; drive_inv(1'b0); enable = 1'b1;
    @(negedge CLK); enable = 1'b0;
    @(negedge CLK); bytes = b; enable = 1'b1;
    @(negedge CLK); enable = 1'b0;
    chk("ign.busy", {127'd0, busy}, 128'd1);
    chk("ign.done_e2", {127'd0, done_flag}, 128'd0);
    @(negedge CLK);
    chk("ign.done_e3", {127'd0, done_flag}, 128'd0);
    @(negedge CLK);
    chk("ign.done", {127'd0, done_flag}, 128'd1);
    chk("ign.result", mix_cols, mix_model(a, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("ign.no_second_done", {127'd0, done_flag}, 128'd0);
      chk("ign.no_second_busy", {127'd0, busy}, 128'd0);
    end
    last_out = mix_model(a, 1'b0, 1'b0);

    // Enable held high: back-to-back every 5 cycles
    a = rnd128(); b = rnd128();
    @(negedge CLK);
    bytes = a; last_round = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge CLK);
    chk("b2b.done_early", {127'd0, done_flag}, 128'd0);
    @(negedge CLK);
    chk("b2b.done1", {127'd0, done_flag}, 128'd1);
    chk("b2b.result1", mix_cols, mix_model(a, 1'b0, 1'b0));
    chk("b2b.busy_gap", {127'd0, busy}, 128'd0);
    bytes = b;
    @(negedge CLK);
    chk("b2b.restart_busy", {127'd0, busy}, 128'd1);
    chk("b2b.restart_done", {127'd0, done_flag}, 128'd0);
    for (int i = 0; i < 3; i++) @(negedge CLK);
    chk("b2b.done2_early", {127'd0, done_flag}, 128'd0);
    @(negedge CLK);
    enable = 1'b0;
    chk("b2b.done2", {127'd0, done_flag}, 128'd1);
    chk("b2b.result2", mix_cols, mix_model(b, 1'b0, 1'b0));
    @(negedge CLK);
    @(negedge CLK);
    chk("b2b.idle", {127'd0, busy}, 128'd0);

    // Asynchronous reset mid-RUN aborts the operation
    @(negedge CLK);
    bytes = rnd128(); last_round = 1'b0; enable = 1'b1;
    @(negedge CLK); enable = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("abort.mix_cols", mix_cols, 128'd0);
    chk("abort.done", {127'd0, done_flag}, 128'd0);
    chk("abort.busy", {127'd0, busy}, 128'd0);
    @(negedge CLK); RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("abort.no_done", {127'd0, done_flag}, 128'd0);
      chk("abort.mix_zero", mix_cols, 128'd0);
    end
    last_out = '0;

    // Recovery after abort
    run_op("recover", r1_in, 1'b0, 1'b0, r1_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mix_columns_iter.md
# mix_columns_iter

Iterative AES-128 MixColumns stage. It sits downstream of the SubBytes/ShiftRows stages in the round datapath. It captures a 128-bit state on `enable` and processes one 32-bit column per clock over 4 cycles. It then presents the full result with a one-cycle `done_flag` pulse, and bypasses the mix on the final round.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `CLK` input 1 — clock, rising edge.
- `RST` input 1 — reset, asynchronous, active-low; clock is `CLK`.
- `bytes` input [0:127] — input state, FIPS-197 column-major.
  - Byte k is `bytes[8k +: 8]`.
  - Column c is `bytes[32c +: 32]`; row r of column c is `bytes[32c+8r +: 8]`.
- `enable` input 1 — start request; sampled only in IDLE.
- `last_round` input 1 — sampled with `enable`; 1 = skip MixColumns (pass-through).
- `inverse` input 1 — present only when `MIX_COLUMNS_INV_EN` is defined; sampled with `enable`.
- `mix_cols` output reg [0:127] — result state, same byte ordering as `bytes`.
- `done_flag` output reg 1 — one-cycle pulse; `mix_cols` is valid from this cycle onward.
- `busy` output reg 1 — high while an operation is in progress.

## Operation
State machine: IDLE, RUN.

IDLE:
- If `enable`=1, capture the following and go to RUN:
  - `bytes` into internal `state_q[0:127]`;
  - `last_round` into `lr_q`;
  - `inverse` into `inv_q` (when the macro is defined);
  - `col_cnt` (2 bits) = 0.
- `busy` goes to 1 at the same edge.

RUN, with `lr_q`=1:
- At the next edge, `mix_cols` = `state_q` unchanged.
- `done_flag`=1, `busy`=0, go to IDLE.

RUN, with `lr_q`=0, on each edge:
- Column `col_cnt` of `state_q` is replaced by its mixed value.
- `col_cnt` increments.
- When `col_cnt`=3, the completed `state_q` (with column 3 mixed) is written to `mix_cols`. `done_flag`=1, `busy`=0, go to IDLE.

Forward mix, per column (a0..a3):
- b0 = 2a0^3a1^a2^a3
- b1 = a0^2a1^3a2^a3
- b2 = a0^a1^2a2^3a3
- b3 = 3a0^a1^a2^2a3

Field arithmetic:
- xtime(x) = {x[1:7],1'b0} ^ (x[0] ? 8'h1b : 8'h00), using `[0:7]` ordering with bit 0 as MSB.
- 3x = xtime(x)^x.
- All arithmetic is 8-bit GF(2^8); there are no carries.

Output and flag rules:
- `mix_cols` changes only on the done edge. Intermediate columns are never visible on it.
- `mix_cols` holds its value between operations.
- `done_flag` is 0 in every cycle except the one following the done edge.

Boundary conditions:
- `enable` while `busy`=1 is ignored. It is not queued, and the current operation is unaffected.
- `enable` held high continuously starts a new operation in the cycle `done_flag` is high. The FSM is IDLE in that cycle, so back-to-back throughput is 1 state per 5 cycles.
- Changes on `bytes`/`last_round`/`inverse` after capture have no effect.
- `RST` low at any time, including mid-RUN, immediately clears the FSM to IDLE:
  - `col_cnt`=0, `mix_cols`=0, `done_flag`=0, `busy`=0;
  - `state_q`=0, `lr_q`=0, `inv_q`=0.
  - The partial operation is discarded and no `done_flag` is emitted.

## Timing
- Reset values: `mix_cols`=128'h0, `done_flag`=0, `busy`=0.
- Let edge E0 be the edge where `enable` is sampled high in IDLE.
- Normal round: columns are mixed at E1..E4. `mix_cols` is updated and `done_flag`=1 at E4, so latency is 4 cycles; `done_flag` drops at E5.
- Last round: `mix_cols` is updated and `done_flag`=1 at E1, so latency is 1 cycle.
- `busy`: 1 from E0 through the done edge, 0 after it.
- Combinational depth: one column mixer (xtime plus 4-input XOR per byte), shared across the 4 cycles.

## Configuration
Macro `MIX_COLUMNS_INV_EN`.

Defined:
- The `inverse` port exists.
- When `inv_q`=1, the column uses InvMixColumns coefficients:
  - b0 = e·a0^b·a1^d·a2^9·a3, rotated per row like the forward mix;
  - 9x, bx, dx and ex are built from three chained xtime stages.
- When `inv_q`=0, behaviour is identical to the undefined case.
- `last_round`=1 still bypasses the mix regardless of `inverse`.

Undefined:
- No `inverse` port, forward mix only, and no inverse logic is synthesised.

## Test plan
- Reset: assert `RST`=0 asynchronously mid-cycle → `mix_cols`=0, `done_flag`=0, `busy`=0 immediately. Release it, hold `enable`=0 for 10 cycles → outputs stay at 0.
- FIPS-197 round 1:
  - `bytes`=d4bf5d30e0b452aeb84111f11e2798e5, `last_round`=0.
  - Expect `mix_cols`=046681e5e0cb199a48f8d37a2806264c and `done_flag` high exactly 4 cycles after the enable edge, for 1 cycle.
- Known columns:
  - `bytes`=db135345f20a225c01010101c6c6c6c6 → 8e4da1bc9fdc589d01010101c6c6c6c6.
  - `bytes`=d4d4d4d52d26314c0000000000000000 → d5d5d7d64d7ebdf80000000000000000.
- Last round: `last_round`=1 with the round-1 input above → `mix_cols` equals the input and `done_flag` is high 1 cycle after the enable edge.
- Busy/ignore/reset-abort:
  - Pulse `enable` again at E2 with a different `bytes` → the result matches the first input only, and there is a single `done_flag`.
  - Assert `RST` at E2 → no `done_flag`, and `mix_cols` stays 0.
- `MIX_COLUMNS_INV_EN` defined, `inverse`=1, `bytes`=046681e5e0cb199a48f8d37a2806264c → d4bf5d30e0b452aeb84111f11e2798e5 after 4 cycles.
